vc_tdm_domain_arbiter: RTL



---
 rtl/vc_tdm_domain_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/vc_tdm_domain_arbiter.sv
// -----------------------------------------------------------------------------
// vc_tdm_domain_arbiter
//
// Two-domain time-division arbiter for the ring network injection path.
// One output channel is shared between a domain-0 and a domain-1 requester.
// Ownership alternates in fixed slots of p_slot_len cycles. Slot boundaries
// come only from a free-running counter. Request and backpressure activity
// never move them, so one domain cannot influence the other's grant timing.
//
// Optional build macro:
//   VC_TDM_GUARD_EN : the final cycle of every slot is a guard cycle. No
//                     handshake is granted on it, so downstream registers
//                     drain before the security label (sel) changes. With
//                     this macro p_slot_len must be >= 2.
//
// Parameters:
//   p_nbits    : payload width in bits
//   p_slot_len : cycles per domain slot (>= 1, or >= 2 with guard)
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high reset
//   in0_val    : domain-0 request valid
//   in0_rdy    : domain-0 request accepted this cycle
//   in0_msg    : domain-0 payload
//   in1_val    : domain-1 request valid
//   in1_rdy    : domain-1 request accepted this cycle
//   in1_msg    : domain-1 payload
//   out_val    : output channel valid
//   out_rdy    : downstream ready
//   out_msg    : payload of the owning domain (combinational mux)
//   sel        : owning domain (registered); also the label of out_msg
//   slot_last  : high on the final cycle of the current slot
// -----------------------------------------------------------------------------
module vc_tdm_domain_arbiter #(
   parameter int p_nbits    = 32,
   parameter int p_slot_len = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in0_val,
   output logic               in0_rdy,
   input  logic [p_nbits-1:0] in0_msg,
   input  logic               in1_val,
   output logic               in1_rdy,
   input  logic [p_nbits-1:0] in1_msg,
   output logic               out_val,
   input  logic               out_rdy,
   output logic [p_nbits-1:0] out_msg,
   output logic               sel,
   output logic               slot_last
);

   localparam int               LP_CNT_W = (p_slot_len > 1) ? $clog2(p_slot_len) : 1;
   localparam logic [LP_CNT_W-1:0] LP_LAST = LP_CNT_W'(p_slot_len - 1);
   localparam logic [LP_CNT_W-1:0] LP_ONE  = LP_CNT_W'(1);

   typedef enum logic {
      SLOT_D0 = 1'b0,
      SLOT_D1 = 1'b1
   } slot_state_t;

   slot_state_t           r_state;
   slot_state_t           w_state_nxt;
   logic [LP_CNT_W-1:0]   r_slot_cnt;
   logic [LP_CNT_W-1:0]   w_slot_cnt_nxt;
   logic                  w_slot_last;
   logic                  w_open;

   assign w_slot_last = (r_slot_cnt == LP_LAST);

   // State register. Reset clears the slot immediately, mid-slot included.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= SLOT_D0;
         r_slot_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_slot_cnt <= w_slot_cnt_nxt;
      end
   end

   // Next state. The counter advances every cycle. Handshake inputs are
   // deliberately absent here, which keeps the slot timing non-interfering.
   always_comb begin
      w_state_nxt    = r_state;
      w_slot_cnt_nxt = r_slot_cnt + LP_ONE;
      if (w_slot_last) begin
         w_slot_cnt_nxt = '0;
         case (r_state)
            SLOT_D0: w_state_nxt = SLOT_D1;
            SLOT_D1: w_state_nxt = SLOT_D0;
            default: w_state_nxt = SLOT_D0;
         endcase
      end
   end

   // Outputs. Reset also closes the channel, so no handshake is granted
   // while reset is held, even though the state already reads SLOT_D0.
   always_comb begin
      sel       = (r_state == SLOT_D1);
      slot_last = w_slot_last;
`ifdef VC_TDM_GUARD_EN
      w_open    = ~reset & ~w_slot_last;
`else
      w_open    = ~reset;
`endif
      // Each rdy depends only on ownership and out_rdy, never on the other
      // domain's val.
      in0_rdy   = w_open & ~sel & out_rdy;
      in1_rdy   = w_open &  sel & out_rdy;
      out_val   = w_open & (sel ? in1_val : in0_val);
      out_msg   = sel ? in1_msg : in0_msg;
   end

endmodule
